// File: rtl/idft_post_scale_pkg.sv
// Shared constants and types for the inverse-DFT output scaler.
// IEEE-754 single field positions and the complex sample bundle.
package idft_post_scale_pkg;

    localparam int          FP_SIGN     = 31;
    localparam int          FP_EXP_MSB  = 30;
    localparam int          FP_EXP_LSB  = 23;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
    localparam logic [31:0] FP_POS_ZERO = 32'h0;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

endpackage

// File: rtl/idft_post_scale_scale.sv
// Multiply one IEEE-754 single by 2^-LOG2N via exponent decrement.
// Denormals and results below the normal range flush to +0.
module fp_pow2_scale
    import idft_post_scale_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic [31:0] word_i,
    output logic [31:0] word_o,
    output logic        udf_o
);

    localparam logic [7:0] SHIFT = 8'(LOG2N);

    logic [7:0] exp_w;

    assign exp_w = word_i[FP_EXP_MSB:FP_EXP_LSB];

    always_comb begin
        word_o = word_i;
        udf_o  = 1'b0;
        if (exp_w == 8'h00) begin
            word_o = FP_POS_ZERO;
            udf_o  = |word_i[FP_EXP_LSB-1:0];
        end else if (exp_w != FP_EXP_MAX) begin
            if (exp_w <= SHIFT) begin
                word_o = FP_POS_ZERO;
                udf_o  = 1'b1;
            end else begin
                word_o[FP_EXP_MSB:FP_EXP_LSB] = exp_w - SHIFT;
            end
        end
    end

endmodule

// File: rtl/idft_post_scale.sv
// Inverse-DFT output stage: conjugate and 1/N scale of forward bins.
// Two-stage valid/ready pipeline with bin counting and sticky errors.
module idft_post_scale
    import idft_post_scale_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_re,
    input  logic [31:0]      in_im,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_re,
    output logic [31:0]      out_im,
    output logic             out_last,
    output logic [LOG2N-1:0] out_idx,
    output logic             frame_err,
    output logic             udf_err,
    input  logic             clr_err
);

    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    logic             s1_valid_q, s1_valid_d;
    cplx_t            s1_data_q, s1_data_d;
    logic             s1_last_q, s1_last_d;
    logic [LOG2N-1:0] s1_idx_q, s1_idx_d;

    logic             s2_valid_q, s2_valid_d;
    cplx_t            s2_data_q, s2_data_d;
    logic             s2_last_q, s2_last_d;
    logic [LOG2N-1:0] s2_idx_q, s2_idx_d;

    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic             ferr_q, ferr_d;
    logic             uerr_q, uerr_d;

    logic        s2_free, s1_move, in_fire, at_end;
    logic        udf_re, udf_im;
    logic [31:0] scl_re, scl_im;
    cplx_t       conj_w;

    fp_pow2_scale #(.LOG2N(LOG2N)) u_scale_re (
        .word_i (in_re),
        .word_o (scl_re),
        .udf_o  (udf_re)
    );

    fp_pow2_scale #(.LOG2N(LOG2N)) u_scale_im (
        .word_i (in_im),
        .word_o (scl_im),
        .udf_o  (udf_im)
    );

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_move  = s1_valid_q && s2_free;
    assign in_ready = rst_n && (!s1_valid_q || s2_free);
    assign in_fire  = in_valid && in_ready;
    assign at_end   = (cnt_q == LAST_IDX);

    // Zero magnitudes always leave as +0, so the sign flip skips them.
    always_comb begin
        conj_w.re = scl_re;
        conj_w.im = {~scl_im[FP_SIGN], scl_im[FP_SIGN-1:0]};
        if (scl_re[FP_SIGN-1:0] == 31'h0)
            conj_w.re = FP_POS_ZERO;
        if (scl_im[FP_SIGN-1:0] == 31'h0)
            conj_w.im = FP_POS_ZERO;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_last_d  = s1_last_q;
        s1_idx_d   = s1_idx_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_last_d  = s2_last_q;
        s2_idx_d   = s2_idx_q;
        cnt_d      = cnt_q;
        ferr_d     = ferr_q && !clr_err;
        uerr_d     = uerr_q && !clr_err;

        if (s1_move)
            s1_valid_d = 1'b0;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_data_d  = conj_w;
            s1_last_d  = in_last;
            s1_idx_d   = cnt_q;
            cnt_d      = (in_last || at_end) ? '0 : cnt_q + 1'b1;
            if (in_last != at_end)
                ferr_d = 1'b1;
            if (udf_re || udf_im)
                uerr_d = 1'b1;
        end

        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = s1_data_q;
                s2_last_d = s1_last_q;
                s2_idx_d  = s1_idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_last_q  <= 1'b0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
            s2_idx_q   <= '0;
            cnt_q      <= '0;
            ferr_q     <= 1'b0;
            uerr_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_last_q  <= s1_last_d;
            s1_idx_q   <= s1_idx_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_last_q  <= s2_last_d;
            s2_idx_q   <= s2_idx_d;
            cnt_q      <= cnt_d;
            ferr_q     <= ferr_d;
            uerr_q     <= uerr_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_re    = s2_data_q.re;
    assign out_im    = s2_data_q.im;
    assign out_last  = s2_last_q;
    assign out_idx   = s2_idx_q;
    assign frame_err = ferr_q;
    assign udf_err   = uerr_q;

endmodule

// File: tb/tb_idft_post_scale.sv
// Bench for idft_post_scale: directed plan steps plus random traffic
// checked against a queue-based model of 1/N scaling and conjugation.
module tb_idft_post_scale;

    localparam int L = 3;
    localparam int N = 1 << L;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, in_last;
    logic [31:0]   in_re, in_im, out_re, out_im;
    logic          out_valid, out_ready, out_last;
    logic [L-1:0]  out_idx;
    logic          frame_err, udf_err, clr_err;

    idft_post_scale #(.LOG2N(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .frame_err (frame_err),
        .udf_err   (udf_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] re;
        logic [31:0] im;
        int          idx;
        logic        last;
        int          t;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_cnt = 0;
    logic m_ferr = 1'b0;
    logic m_uerr = 1'b0;
    logic fired;
    int   stall_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Value divided by N; anything that would fall below the normal range is +0.
    function automatic logic [31:0] div_n(input logic [31:0] x,
                                          output logic uf);
        int e;
        e  = int'(x[30:23]);
        uf = 1'b0;
        if (e == 0) begin
            uf = (x[22:0] != 0);
            return 32'h0;
        end
        if (e == 255) return x;
        if (e - L < 1) begin
            uf = 1'b1;
            return 32'h0;
        end
        return x - (32'(L) << 23);
    endfunction

    function automatic logic [31:0] pos0(input logic [31:0] x);
        return ((x & 32'h7FFF_FFFF) == 0) ? 32'h0 : x;
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [7:0] e;
        int sel;
        sel = int'($urandom_range(0, 7));
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'($urandom_range(1, L));
            2:       e = 8'hFF;
            default: e = 8'($urandom_range(L + 1, 254));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic tick();
        exp_t e;
        logic s1v, s2v, uf_r, uf_i, set_f, set_u, at_end;
        #2;
        fired = 1'b0;
        if (!rst_n) begin
            chk("in_ready_rst", in_ready, 0);
            q.delete();
            m_cnt  = 0;
            m_ferr = 1'b0;
            m_uerr = 1'b0;
        end else begin
            s2v = (q.size() > 0) && (cyc - q[0].t >= 2);
            s1v = (q.size() == 2) || (q.size() == 1 && !s2v);
            chk("out_valid", out_valid, s2v);
            chk("in_ready", in_ready, !s1v || !s2v || out_ready);
            chk("frame_err", frame_err, m_ferr);
            chk("udf_err", udf_err, m_uerr);
            if (!in_ready) stall_seen++;
            if (s2v && out_valid) begin
                chk("out_re", out_re, q[0].re);
                chk("out_im", out_im, q[0].im);
                chk("out_idx", out_idx, q[0].idx);
                chk("out_last", out_last, q[0].last);
            end
            if (out_valid && out_ready && q.size() > 0)
                void'(q.pop_front());
            set_f = 1'b0;
            set_u = 1'b0;
            if (in_valid && in_ready) begin
                fired  = 1'b1;
                at_end = (m_cnt == N - 1);
                e.re   = pos0(div_n(in_re, uf_r));
                e.im   = pos0(div_n(in_im, uf_i) ^ 32'h8000_0000);
                e.idx  = m_cnt;
                e.last = in_last;
                e.t    = cyc;
                q.push_back(e);
                set_f  = (in_last != at_end);
                set_u  = uf_r || uf_i;
                m_cnt  = (in_last || at_end) ? 0 : m_cnt + 1;
            end
            m_ferr = set_f || (m_ferr && !clr_err);
            m_uerr = set_u || (m_uerr && !clr_err);
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im,
                        input logic last);
        int n;
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fired && n < 20);
        checks++;
        if (!fired) begin
            errors++;
            $error("FAIL send_timeout observed=%0d expected=<20", n);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    initial begin
        int i;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        @(negedge clk);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);

        send(32'h3F80_0000, 32'h4000_0000, 1'b0);
        tick();
        chk("lat_valid", out_valid, 1);
        chk("basic_re", out_re, 32'h3E00_0000);
        chk("basic_im", out_im, 32'hBE80_0000);
        chk("basic_idx", out_idx, 0);

        send(32'h8000_0000, 32'h0000_0000, 1'b0);
        tick();
        chk("zero_re", out_re, 32'h0);
        chk("zero_im", out_im, 32'h0);

        send(32'h3F80_0000, 32'hC000_0000, 1'b0);
        tick();
        chk("neg_im", out_im, 32'h3E80_0000);

        send(32'h0180_0000, 32'h7F80_0000, 1'b0);
        chk("udf_set", udf_err, 1);
        tick();
        chk("udf_re", out_re, 32'h0);
        chk("inf_im", out_im, 32'hFF80_0000);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("udf_clr", udf_err, 0);

        send(32'h4040_0000, 32'h4040_0000, 1'b1);
        chk("frame_set", frame_err, 1);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        tick();
        chk("resync_idx", out_idx, 0);
        drain();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;

        send(32'h3F80_0000, 32'h3F80_0000, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        drain();

        stall_seen = 0;
        i = 0;
        for (int c = 0; c < 40 && (i < 8 || q.size() > 0); c++) begin
            out_ready = !(c >= 3 && c < 6);
            in_valid  = (i < 8);
            in_re     = rnd_word();
            in_im     = rnd_word();
            in_last   = (i == 7);
            tick();
            if (fired) i++;
        end
        chk("stream_count", i, 8);
        chk("stream_stall", stall_seen > 0, 1);
        chk("stream_ferr", frame_err, 0);
        drain();

        for (int c = 0; c < 400; c++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_re     = rnd_word();
            in_im     = rnd_word();
            in_last   = ($urandom_range(0, 11) == 0) ||
                        (m_cnt == N - 1 && $urandom_range(0, 4) != 0);
            clr_err   = ($urandom_range(0, 15) == 0);
            tick();
        end
        clr_err = 1'b0;
        drain();

        out_ready = 1'b0;
        send(32'h0000_0001, 32'h3F80_0000, 1'b1);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        chk("full_ready", in_ready, 0);
        chk("pre_rst_ferr", frame_err, 1);
        chk("pre_rst_uerr", udf_err, 1);
        rst_n = 1'b0;
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_uerr", udf_err, 0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        send(32'h4100_0000, 32'h4100_0000, 1'b0);
        tick();
        chk("post_rst_idx", out_idx, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idft_post_scale.md
Name: idft_post_scale

Overview:
- Output stage of the inverse-DFT path, which uses IDFT(x) = conj(DFT(conj(x)))/N.
- Takes forward-DFT bins as complex IEEE-754 single-precision pairs and applies the final conjugate and 1/N scaling.
- N is a power of two, so scaling is an exponent decrement.
- Pipelined with valid/ready handshakes on both sides; tracks frame position and flags framing and underflow errors.

Parameters:
- LOG2N, 3, log2 of transform size N (1..7); scale factor is 2^-LOG2N.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  upstream sample valid
- in_ready  output  1  block can accept sample
- in_re  input  32  real part, IEEE-754 single
- in_im  input  32  imaginary part, IEEE-754 single
- in_last  input  1  marks last bin of frame
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream can accept
- out_re  output  32  scaled real part
- out_im  output  32  scaled, negated imaginary part
- out_last  output  1  last bin of frame, aligned with out data
- out_idx  output  LOG2N  bin index of the output sample
- frame_err  output  1  sticky: in_last disagreed with bin count
- udf_err  output  1  sticky: a nonzero finite input flushed to zero
- clr_err  input  1  clears both sticky flags

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low.
- Reset values: all valids 0, in_ready 0 during reset, out_* data 0, out_last 0, out_idx 0, bin counter 0, frame_err 0, udf_err 0.
- Reset mid-operation flushes both stages; in-flight samples are discarded.
- Pipeline: S1 decodes and scales, S2 is the output register. Latency is 2 cycles from input handshake to out_valid when out_ready is held 1. Throughput is 1 sample/cycle.
- Stage advance rule: a stage loads when it is empty or its contents move on in the same cycle.
  - S2 moves when out_ready = 1.
  - in_ready = !S1_valid || S1_moves.
- out_* hold stable while out_valid && !out_ready.
- Transfer occurs only when valid && ready are both 1 in the same cycle.
- Per-component scaling (e = bits[30:23]):
  - e == 0 (zero or denormal): result +0 (0x00000000). Denormals are flushed; udf_err is set if the mantissa is nonzero.
  - e == 255 (inf/NaN): pass exponent and mantissa unchanged.
  - 1 <= e <= LOG2N: result +0, set udf_err.
  - otherwise: e := e - LOG2N; sign and mantissa unchanged.
- Conjugate: after scaling, out_im sign bit is inverted, except when the scaled imaginary part is zero, which gives +0. A -0 output is never produced on either component; a real zero is also forced to +0.
- NaN imaginary part: the sign is still inverted.
- Bin counter (S1 entry side):
  - Increments on each accepted sample and is carried as out_idx.
  - Wraps from N-1 to 0.
  - On accepted in_last, the counter returns to 0.
- frame_err is set when in_last is accepted with count != N-1, or when count == N-1 is accepted without in_last. In both cases the counter resyncs to 0.
- Sticky flags:
  - Set in the cycle the offending sample enters S1.
  - clr_err clears them; a set event in the same cycle as clr_err wins (flag = 1).

Decomposition:
- Shared package holds:
  - field constants: FP_SIGN = 31, FP_EXP_MSB = 30, FP_EXP_LSB = 23, FP_EXP_MAX = 8'hFF, FP_POS_ZERO = 32'h0;
  - a typedef for a complex sample {re, im} of two 32-bit words.
- One combinational sub-module, fp_pow2_scale: input a 32-bit word; outputs the scaled word and an underflow flag.
  - Instantiated twice in S1.
  - The conjugate sign flip and the -0 suppression stay in the top level.

Test Plan:
- LOG2N = 3, in = (0x3F800000, 0x40000000), out_ready = 1 -> two cycles later out = (0x3E000000, 0xBE800000), out_idx 0, no flags.
- in = (0x80000000, 0x00000000) -> out = (0x00000000, 0x00000000); in_im = 0xC0000000 -> out_im = 0x3E800000.
- in_re = 0x01800000 (e = 3) -> out_re = 0, udf_err = 1; clr_err pulse -> 0. in_im = 0x7F800000 -> out_im = 0xFF800000.
- Stream 8 samples with in_last on the 8th, holding out_ready = 0 for 3 cycles mid-stream:
  - no loss or duplication; out_idx reads 0..7;
  - out_last appears only with idx 7;
  - in_ready drops after 2 samples are buffered.
- in_last on the 5th sample -> frame_err = 1; the next sample gets out_idx 0.
- Assert rst_n = 0 with both stages full -> out_valid = 0 next cycle; flags and counter return to 0.
